// File: rtl/arb4_rr_ctrl.sv
// Four-requester arbiter with round-robin or fixed-priority selection, grant hold,
// and a per-ownership timeout that evicts and masks a stuck owner until it drops req.
module arb4_rr_ctrl #(
  parameter int          RR_EN    = 1,
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]       state, state_d;
  logic [3:0]       gnt_d;
  logic [1:0]       gnt_id_d;
  logic             timeout_d;
  logic [CNT_W-1:0] hold_cnt, hold_cnt_d;
  logic [3:0]       mask, mask_d;
  logic [1:0]       rr_ptr, rr_ptr_d;
  logic [3:0]       elig;
  logic [1:0]       win;
  logic             owner_req;
  logic             hold_at_max;

  // First eligible index after ptr, wrapping; i=4 lands back on ptr itself.
  function automatic logic [1:0] pick_rr(input logic [3:0] e, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] res;
    logic       found;
    res   = ptr;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr + 2'(i);
      if (!found && e[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [1:0] pick_hi(input logic [3:0] e);
    logic [1:0] res;
    res = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (e[i]) res = 2'(i);
    end
    return res;
  endfunction

  assign elig        = req & ~mask;
  assign win         = (RR_EN != 0) ? pick_rr(elig, rr_ptr) : pick_hi(elig);
  assign owner_req   = req[gnt_id];
  assign hold_at_max = (HOLD_MAX != 0) && (hold_cnt == CNT_W'(HOLD_MAX));
  assign gnt_valid   = |gnt;

  always_comb begin
    state_d    = state;
    gnt_d      = gnt;
    gnt_id_d   = gnt_id;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt;
    mask_d     = mask & req;
    rr_ptr_d   = rr_ptr;
    case (state)
      ST_IDLE: begin
        if (|elig) begin
          state_d    = ST_GRANT;
          gnt_d      = 4'b0001 << win;
          gnt_id_d   = win;
          hold_cnt_d = CNT_W'(1);
          rr_ptr_d   = win;
        end
      end
      ST_GRANT: begin
        // Release wins over timeout when both happen on the same edge.
        if (!owner_req) begin
          state_d    = ST_IDLE;
          gnt_d      = 4'b0000;
          hold_cnt_d = '0;
        end else if (hold_at_max) begin
          state_d        = ST_IDLE;
          gnt_d          = 4'b0000;
          timeout_d      = 1'b1;
          mask_d[gnt_id] = 1'b1;
          hold_cnt_d     = '0;
        end else if (hold_cnt != '1) begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      gnt      <= 4'b0000;
      gnt_id   <= 2'd0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      mask     <= 4'b0000;
      rr_ptr   <= 2'd3;
    end else begin
      state    <= state_d;
      gnt      <= gnt_d;
      gnt_id   <= gnt_id_d;
      timeout  <= timeout_d;
      hold_cnt <= hold_cnt_d;
      mask     <= mask_d;
      rr_ptr   <= rr_ptr_d;
    end
  end

endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// Scoreboard bench for arb4_rr_ctrl: three instances with different parameter sets,
// directed req vectors with hand-computed expected outputs checked one cycle later.
module tb_arb4_rr_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req_a = 4'b0000, req_b = 4'b0000, req_c = 4'b0000;
  logic [3:0] gnt_a, gnt_b, gnt_c;
  logic [1:0] gnt_id_a, gnt_id_b, gnt_id_c;
  logic       gnt_valid_a, gnt_valid_b, gnt_valid_c;
  logic       timeout_a, timeout_b, timeout_c;

  always #5 clk = ~clk;

  // A: round-robin, timeout 4. B: round-robin, no timeout. C: fixed priority.
  arb4_rr_ctrl #(.RR_EN(1), .HOLD_MAX(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .gnt(gnt_a), .gnt_id(gnt_id_a),
    .gnt_valid(gnt_valid_a), .timeout(timeout_a));
  arb4_rr_ctrl #(.RR_EN(1), .HOLD_MAX(0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .gnt(gnt_b), .gnt_id(gnt_id_b),
    .gnt_valid(gnt_valid_b), .timeout(timeout_b));
  arb4_rr_ctrl #(.RR_EN(0), .HOLD_MAX(16), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .req(req_c), .gnt(gnt_c), .gnt_id(gnt_id_c),
    .gnt_valid(gnt_valid_c), .timeout(timeout_c));

  typedef struct {
    int         d;
    logic [3:0] g;
    logic [1:0] id;
    logic       to;
  } exp_t;

  exp_t sb[$];
  exp_t rec;
  int   checks = 0;
  int   errors = 0;
  int   cyc_n  = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got {gnt,id,vld,to}=%b required %b", name, act, want);
    end
  endtask

  task automatic expect_next(input int d, input logic [3:0] g, input logic [1:0] id,
                             input logic to);
    exp_t e;
    e.d = d; e.g = g; e.id = id; e.to = to;
    sb.push_back(e);
  endtask

  task automatic cyc(input int d, input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] id, input logic to);
    @(negedge clk);
    case (d)
      0: req_a = r;
      1: req_b = r;
      default: req_c = r;
    endcase
    expect_next(d, g, id, to);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req_a = 4'b0000; req_b = 4'b0000; req_c = 4'b0000;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every expectation is compared just after the edge it describes.
  always @(posedge clk) begin
    cyc_n++;
    #1;
    if (sb.size() > 0) begin
      logic [7:0] act;
      rec = sb.pop_front();
      case (rec.d)
        0: act = {gnt_a, gnt_id_a, gnt_valid_a, timeout_a};
        1: act = {gnt_b, gnt_id_b, gnt_valid_b, timeout_b};
        default: act = {gnt_c, gnt_id_c, gnt_valid_c, timeout_c};
      endcase
      check($sformatf("dut%0d_cyc%0d", rec.d, cyc_n), act, {rec.g, rec.id, |rec.g, rec.to});
    end
  end

  initial begin
    // Reset held with all requests high.
    req_a = 4'b1111;
    for (int i = 0; i < 3; i++) cyc(0, 4'b1111, 4'b0000, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    expect_next(0, 4'b0001, 2'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_grant", {gnt_a, gnt_id_a, gnt_valid_a, timeout_a}, 8'h00);
    req_a = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Single requester on B, held 5 cycles then released.
    for (int i = 0; i < 5; i++) cyc(1, 4'b0100, 4'b0100, 2'd2, 1'b0);
    cyc(1, 4'b0000, 4'b0000, 2'd2, 1'b0);
    cyc(1, 4'b0000, 4'b0000, 2'd2, 1'b0);

    // Round-robin rotation on B: order 0,1,2,3,0 with one idle cycle between owners.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      logic [3:0] drop;
      oh   = 4'b0001 << k;
      drop = 4'b1111 & ~oh;
      for (int i = 0; i < 3; i++) cyc(1, 4'b1111, oh, 2'(k), 1'b0);
      cyc(1, drop, 4'b0000, 2'(k), 1'b0);
    end
    cyc(1, 4'b1111, 4'b0001, 2'd0, 1'b0);
    cyc(1, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Fixed priority on C: highest index wins, no rotation.
    cyc(2, 4'b0110, 4'b0100, 2'd2, 1'b0);
    cyc(2, 4'b0110, 4'b0100, 2'd2, 1'b0);
    cyc(2, 4'b0010, 4'b0000, 2'd2, 1'b0);
    cyc(2, 4'b0110, 4'b0100, 2'd2, 1'b0);
    cyc(2, 4'b0000, 4'b0000, 2'd2, 1'b0);
    cyc(2, 4'b0011, 4'b0010, 2'd1, 1'b0);
    cyc(2, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // Timeout on A: 4 grant cycles, one-cycle pulse, masked until req0 drops.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 4'b0001, 4'b0001, 2'd0, 1'b0);
    cyc(0, 4'b0001, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(0, 4'b0001, 4'b0000, 2'd0, 1'b0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(0, 4'b0001, 4'b0001, 2'd0, 1'b0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Masked owner vs. other requester on A.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(0, 4'b0011, 4'b0001, 2'd0, 1'b0);
    cyc(0, 4'b0011, 4'b0000, 2'd0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(0, 4'b0011, 4'b0010, 2'd1, 1'b0);
    cyc(0, 4'b0011, 4'b0000, 2'd1, 1'b1);
    cyc(0, 4'b0011, 4'b0000, 2'd1, 1'b0);
    cyc(0, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // Release on the same edge the hold count reaches its limit: no timeout, no mask.
    for (int i = 0; i < 4; i++) cyc(0, 4'b0001, 4'b0001, 2'd0, 1'b0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0);
    cyc(0, 4'b0001, 4'b0001, 2'd0, 1'b0);
    cyc(0, 4'b0000, 4'b0000, 2'd0, 1'b0);

    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
